// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave endpoint.
// Fixed SPI mode 0: sclk idles low, data is sampled on the rising edge.
package spi_pkg;

  // Frame state of the slave endpoint
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_t;

  // SPI mode constants (mode 0 only)
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  // Default frame width
  localparam int SPI_DATA_W_DEFAULT = 8;

  // Fill bit used when a frame starts with an empty shadow register
  localparam logic SPI_EMPTY_FILL = 1'b0;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with registered
// single-cycle rise/fall pulses taken from the last two synchronized samples.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic global_clk,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);

  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [SYNC_N-1:0] sync_r;
  logic              prev_r;
  logic              rise_r;
  logic              fall_r;

  // Synchronize the pin and register edge pulses
  always_ff @(posedge global_clk) begin
    if (reset) begin
      sync_r <= {SYNC_N{RESET_VAL}};
      prev_r <= RESET_VAL;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_N-2:0], din};
      prev_r <= sync_r[SYNC_N-1];
      rise_r <= sync_r[SYNC_N-1] & ~prev_r;
      fall_r <= ~sync_r[SYNC_N-1] & prev_r;
    end
  end

  assign rise = rise_r;
  assign fall = fall_r;

endmodule

// File: rtl/spi_slave_if.sv
// SPI mode-0 slave endpoint, fully oversampled in the global_clk domain.
// Received frames are handed out on rx_data/rx_valid/rx_ack; the next reply
// frame is written into a one-entry shadow register via tx_data/tx_load.
// Optional build macro: SPI_SLAVE_OVERRUN_EN adds rx_overrun (pulse) and
// rx_overrun_sticky (cleared only by reset).
module spi_slave_if
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W_DEFAULT,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              global_clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              ss,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ack,
  output logic              busy
`ifdef SPI_SLAVE_OVERRUN_EN
  ,
  output logic              rx_overrun,
  output logic              rx_overrun_sticky
`endif
);

  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int CNT_W  = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [DATA_W-1:0] EMPTY_FRAME = {DATA_W{SPI_EMPTY_FILL}};

  // Bit that goes on the wire first for a given frame
  function automatic logic first_bit(input logic [DATA_W-1:0] v);
    if (MSB_FIRST != 0) first_bit = v[DATA_W-1];
    else                first_bit = v[0];
  endfunction

  // Frame with the bit just presented removed
  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v);
    if (MSB_FIRST != 0) shift_out = {v[DATA_W-2:0], 1'b0};
    else                shift_out = {1'b0, v[DATA_W-1:1]};
  endfunction

  // Frame with a newly sampled bit appended
  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] v, input logic b);
    if (MSB_FIRST != 0) shift_in = {v[DATA_W-2:0], b};
    else                shift_in = {b, v[DATA_W-1:1]};
  endfunction

  spi_state_t        state_r;
  spi_state_t        state_next_s;
  logic              sclk_rise_s;
  logic              sclk_fall_s;
  logic              ss_rise_s;
  logic              ss_fall_s;
  logic [SYNC_N-1:0] mosi_sync_r;
  logic              mosi_s;
  logic              frame_start_s;
  logic              frame_abort_s;
  logic              bit_rise_s;
  logic              bit_fall_s;
  logic              frame_last_s;
  logic              consume_s;
  logic              load_acc_s;
  logic [DATA_W-1:0] consume_frame_s;
  logic [DATA_W-1:0] tx_shreg_r;
  logic [DATA_W-1:0] shadow_r;
  logic              tx_ready_r;
  logic              miso_r;
  logic [DATA_W-1:0] rx_shreg_r;
  logic [DATA_W-1:0] rx_data_r;
  logic              rx_valid_r;
  logic              done_r;
  logic [CNT_W-1:0]  bit_cnt_r;
  logic              busy_r;

  spi_sync_edge #(.SYNC_STAGES(SYNC_N), .RESET_VAL(SPI_CPOL)) u_sclk_sync (
    .global_clk (global_clk),
    .reset      (reset),
    .din        (sclk),
    .rise       (sclk_rise_s),
    .fall       (sclk_fall_s)
  );

  // ss idles high, so its synchronizer resets high to avoid a false select
  spi_sync_edge #(.SYNC_STAGES(SYNC_N), .RESET_VAL(1'b1)) u_ss_sync (
    .global_clk (global_clk),
    .reset      (reset),
    .din        (ss),
    .rise       (ss_rise_s),
    .fall       (ss_fall_s)
  );

  // mosi needs only the level, so a plain synchronizer chain is enough
  always_ff @(posedge global_clk) begin
    if (reset) begin
      mosi_sync_r <= {SYNC_N{1'b0}};
    end else begin
      mosi_sync_r <= {mosi_sync_r[SYNC_N-2:0], mosi};
    end
  end

  assign mosi_s = mosi_sync_r[SYNC_N-1];

  // Frame state register
  always_ff @(posedge global_clk) begin
    if (reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == SHIFT);
    end
  end

  // Next-state decode and per-cycle frame events
  always_comb begin
    state_next_s  = state_r;
    frame_start_s = 1'b0;
    frame_abort_s = 1'b0;
    bit_rise_s    = 1'b0;
    bit_fall_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (ss_fall_s) begin
          state_next_s  = SHIFT;
          frame_start_s = 1'b1;
        end else begin
          state_next_s  = IDLE;
        end
      end
      SHIFT: begin
        if (ss_rise_s) begin
          state_next_s  = IDLE;
          frame_abort_s = 1'b1;
        end else begin
          state_next_s  = SHIFT;
          bit_rise_s    = sclk_rise_s;
          bit_fall_s    = sclk_fall_s;
        end
      end
      default: begin
        state_next_s  = IDLE;
      end
    endcase
  end

  assign frame_last_s    = bit_rise_s & (bit_cnt_r == LAST_BIT);
  assign consume_s       = frame_start_s | frame_last_s;
  assign load_acc_s      = tx_load & tx_ready_r;
  assign consume_frame_s = tx_ready_r ? EMPTY_FRAME : shadow_r;

  // Shadow register: a load into an empty shadow wins over a same-cycle consume
  always_ff @(posedge global_clk) begin
    if (reset) begin
      shadow_r   <= EMPTY_FRAME;
      tx_ready_r <= 1'b1;
    end else if (load_acc_s) begin
      shadow_r   <= tx_data;
      tx_ready_r <= 1'b0;
    end else if (consume_s) begin
      shadow_r   <= EMPTY_FRAME;
      tx_ready_r <= 1'b1;
    end else begin
      shadow_r   <= shadow_r;
      tx_ready_r <= tx_ready_r;
    end
  end

  // Transmit path: first bit at select, next bit on every sclk fall; the
  // reload at the last rise is kept unshifted so the next fall shows its first bit
  always_ff @(posedge global_clk) begin
    if (reset) begin
      tx_shreg_r <= EMPTY_FRAME;
      miso_r     <= 1'b0;
    end else if (frame_start_s) begin
      tx_shreg_r <= shift_out(consume_frame_s);
      miso_r     <= first_bit(consume_frame_s);
    end else if (frame_abort_s) begin
      tx_shreg_r <= tx_shreg_r;
      miso_r     <= 1'b0;
    end else if (frame_last_s) begin
      tx_shreg_r <= consume_frame_s;
      miso_r     <= miso_r;
    end else if (bit_fall_s) begin
      tx_shreg_r <= shift_out(tx_shreg_r);
      miso_r     <= first_bit(tx_shreg_r);
    end else begin
      tx_shreg_r <= tx_shreg_r;
      miso_r     <= miso_r;
    end
  end

  // Bit counter within the current frame
  always_ff @(posedge global_clk) begin
    if (reset) begin
      bit_cnt_r <= {CNT_W{1'b0}};
    end else if (frame_start_s || frame_abort_s || frame_last_s) begin
      bit_cnt_r <= {CNT_W{1'b0}};
    end else if (bit_rise_s) begin
      bit_cnt_r <= bit_cnt_r + CNT_ONE;
    end else begin
      bit_cnt_r <= bit_cnt_r;
    end
  end

  // Receive shift register and one-cycle completion strobe
  always_ff @(posedge global_clk) begin
    if (reset) begin
      rx_shreg_r <= EMPTY_FRAME;
      done_r     <= 1'b0;
    end else begin
      done_r <= frame_last_s;
      if (frame_start_s) begin
        rx_shreg_r <= EMPTY_FRAME;
      end else if (bit_rise_s) begin
        rx_shreg_r <= shift_in(rx_shreg_r, mosi_s);
      end else begin
        rx_shreg_r <= rx_shreg_r;
      end
    end
  end

  // Hand the completed frame to local logic; a new frame beats a same-cycle ack
  always_ff @(posedge global_clk) begin
    if (reset) begin
      rx_data_r  <= EMPTY_FRAME;
      rx_valid_r <= 1'b0;
    end else if (done_r) begin
      rx_data_r  <= rx_shreg_r;
      rx_valid_r <= 1'b1;
    end else if (rx_ack) begin
      rx_data_r  <= rx_data_r;
      rx_valid_r <= 1'b0;
    end else begin
      rx_data_r  <= rx_data_r;
      rx_valid_r <= rx_valid_r;
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  logic rx_overrun_r;
  logic rx_overrun_sticky_r;

  // Flag a completion that lands on a still-unacknowledged frame
  always_ff @(posedge global_clk) begin
    if (reset) begin
      rx_overrun_r        <= 1'b0;
      rx_overrun_sticky_r <= 1'b0;
    end else begin
      rx_overrun_r <= done_r & rx_valid_r & ~rx_ack;
      if (done_r & rx_valid_r & ~rx_ack) begin
        rx_overrun_sticky_r <= 1'b1;
      end else begin
        rx_overrun_sticky_r <= rx_overrun_sticky_r;
      end
    end
  end

  assign rx_overrun        = rx_overrun_r;
  assign rx_overrun_sticky = rx_overrun_sticky_r;
`endif

  assign miso     = miso_r;
  assign tx_ready = tx_ready_r;
  assign rx_data  = rx_data_r;
  assign rx_valid = rx_valid_r;
  assign busy     = busy_r;

endmodule
